// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and helpers for the VGA configuration register bank.
package vga_axil_pkg;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'd0,
        AXIL_RESP_EXOKAY = 2'd1,
        AXIL_RESP_SLVERR = 2'd2,
        AXIL_RESP_DECERR = 2'd3
    } axil_resp_e;

    // Word index of a byte address; byte_bits is log2 of the bus width in bytes.
    function automatic logic [63:0] axil_reg_idx(input logic [63:0] addr, input int unsigned byte_bits);
        return addr >> byte_bits;
    endfunction

endpackage

// File: rtl/vga_axil_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface vga_axil_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import vga_axil_pkg::*;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    axil_resp_e          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    axil_resp_e          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/vga_axil_hold_buf.sv
// One-entry hold buffer: accepts a payload when empty, keeps it until popped.
module vga_axil_hold_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic arst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    output T     out_data,
    input  logic out_pop
);

    logic full_r;
    T     data_r;

    // Pop has priority; a pop and a refill never share an edge since in_ready is low while full.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (out_pop) begin
            full_r <= 1'b0;
        end else if (in_valid && !full_r) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end
    end

    assign in_ready  = !full_r;
    assign out_valid = full_r;
    assign out_data  = data_r;

endmodule

// File: rtl/vga_axil_regs.sv
// AXI4-Lite register bank for VGA configuration: byte-strobed RW registers,
// read-only hardware-sourced slots and SLVERR on out-of-range or RO writes.
module vga_axil_regs #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         REG_NUM   = 16,
    parameter logic [REG_NUM-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    vga_axil_if.slave                       axil,
    output logic [REG_NUM-1:0][DATA_W-1:0]  regs_o,
    input  logic [REG_NUM-1:0][DATA_W-1:0]  ro_data_i,
    output logic [REG_NUM-1:0]              wr_pulse_o
);
    import vga_axil_pkg::*;

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } aw_pld_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } w_pld_t;

    aw_pld_t aw_in_s, aw_buf_s;
    w_pld_t  w_in_s, w_buf_s;
    logic    aw_ready_s, aw_full_s, w_ready_s, w_full_s;
    logic    commit_s;

    logic [REG_NUM-1:0][DATA_W-1:0] regs_r;
    logic [REG_NUM-1:0]             wr_pulse_r;
    logic                           bvalid_r;
    axil_resp_e                     bresp_r;
    logic                           rvalid_r;
    axil_resp_e                     rresp_r;
    logic [DATA_W-1:0]              rdata_r;

    assign aw_in_s.addr = axil.awaddr;
    assign w_in_s.data  = axil.wdata;
    assign w_in_s.strb  = axil.wstrb;

    vga_axil_hold_buf #(.T(aw_pld_t)) u_aw_buf (
        .clk       (clk_i),
        .arst      (arst_i),
        .in_valid  (axil.awvalid),
        .in_ready  (aw_ready_s),
        .in_data   (aw_in_s),
        .out_valid (aw_full_s),
        .out_data  (aw_buf_s),
        .out_pop   (commit_s)
    );

    vga_axil_hold_buf #(.T(w_pld_t)) u_w_buf (
        .clk       (clk_i),
        .arst      (arst_i),
        .in_valid  (axil.wvalid),
        .in_ready  (w_ready_s),
        .in_data   (w_in_s),
        .out_valid (w_full_s),
        .out_data  (w_buf_s),
        .out_pop   (commit_s)
    );

    // Write decode on the buffered address
    logic [63:0]        aw_idx_s;
    logic [IDX_W-1:0]   aw_sel_s;
    logic               aw_in_range_s;
    logic               wr_ok_s;
    axil_resp_e         wr_resp_s;
    logic [DATA_W-1:0]  merged_s;

    assign aw_idx_s      = axil_reg_idx(64'(aw_buf_s.addr), OFS_W);
    assign aw_sel_s      = aw_idx_s[IDX_W-1:0];
    assign aw_in_range_s = (aw_idx_s < 64'(REG_NUM));
    assign commit_s      = aw_full_s && w_full_s && (!bvalid_r || axil.bready);

    // Byte-merge the buffered write into the addressed register and pick the response.
    always_comb begin
        wr_ok_s   = 1'b0;
        wr_resp_s = AXIL_RESP_OKAY;
        merged_s  = '0;
        if (aw_in_range_s && !RO_MASK[aw_sel_s]) begin
            wr_ok_s = |w_buf_s.strb;
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (w_buf_s.strb[b]) begin
                    merged_s[b*8 +: 8] = w_buf_s.data[b*8 +: 8];
                end else begin
                    merged_s[b*8 +: 8] = regs_r[aw_sel_s][b*8 +: 8];
                end
            end
        end else begin
            wr_resp_s = AXIL_RESP_SLVERR;
        end
    end

    // Register storage, write strobes and the B channel.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            regs_r     <= {REG_NUM{RESET_VAL}};
            wr_pulse_r <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= AXIL_RESP_OKAY;
        end else begin
            wr_pulse_r <= '0;
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_resp_s;
                if (wr_ok_s) begin
                    regs_r[aw_sel_s]     <= merged_s;
                    wr_pulse_r[aw_sel_s] <= 1'b1;
                end
            end else if (axil.bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read decode; regs_r is sampled before any same-edge commit lands
    logic [63:0]      ar_idx_s;
    logic [IDX_W-1:0] ar_sel_s;
    logic             ar_in_range_s;
    logic             ar_ready_s;

    assign ar_idx_s      = axil_reg_idx(64'(axil.araddr), OFS_W);
    assign ar_sel_s      = ar_idx_s[IDX_W-1:0];
    assign ar_in_range_s = (ar_idx_s < 64'(REG_NUM));
    assign ar_ready_s    = !rvalid_r || axil.rready;

    // R channel: capture read data on the AR handshake, hold until accepted.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rvalid_r <= 1'b0;
            rresp_r  <= AXIL_RESP_OKAY;
            rdata_r  <= '0;
        end else if (axil.arvalid && ar_ready_s) begin
            rvalid_r <= 1'b1;
            if (ar_in_range_s) begin
                rresp_r <= AXIL_RESP_OKAY;
                rdata_r <= RO_MASK[ar_sel_s] ? ro_data_i[ar_sel_s] : regs_r[ar_sel_s];
            end else begin
                rresp_r <= AXIL_RESP_SLVERR;
                rdata_r <= '0;
            end
        end else if (axil.rready) begin
            rvalid_r <= 1'b0;
        end
    end

    assign axil.awready = aw_ready_s;
    assign axil.wready  = w_ready_s;
    assign axil.bvalid  = bvalid_r;
    assign axil.bresp   = bresp_r;
    assign axil.arready = ar_ready_s;
    assign axil.rvalid  = rvalid_r;
    assign axil.rresp   = rresp_r;
    assign axil.rdata   = rdata_r;
    assign regs_o       = regs_r;
    assign wr_pulse_o   = wr_pulse_r;

endmodule

// File: tb/tb_vga_axil_regs.sv
// Bench for vga_axil_regs: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based bus model.
module tb_vga_axil_regs;
    import vga_axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RN = 16;
    localparam int BB = DW / 8;
    localparam logic [RN-1:0] RO = 16'h0001;
    localparam logic [DW-1:0] RV = 32'hA5A5_5A5A;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    vga_axil_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();
    logic [RN-1:0][DW-1:0] regs;
    logic [RN-1:0][DW-1:0] ro_data;
    logic [RN-1:0]         wr_pulse;

    vga_axil_regs #(
        .DATA_W(DW), .ADDR_W(AW), .REG_NUM(RN), .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .clk_i(clk), .arst_i(arst), .axil(axil),
        .regs_o(regs), .ro_data_i(ro_data), .wr_pulse_o(wr_pulse)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [RN*DW-1:0] got, input logic [RN*DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    // Behavioural model: registers as an array, AW/W acceptance as queues
    logic [DW-1:0] m_regs [RN];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] wd_q [$];
    logic [BB-1:0] ws_q [$];
    bit            m_bvalid, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [DW-1:0] m_rdata;
    logic [RN-1:0] m_pulse;
    bit            aw_hs, w_hs, ar_hs;
    int            ar_cnt = 0;

    always @(posedge clk or posedge arst) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BB-1:0] s;
        bit            b_free;
        if (arst) begin
            for (int k = 0; k < RN; k++) m_regs[k] = RV;
            aw_q.delete(); wd_q.delete(); ws_q.delete();
            m_bvalid = 0; m_rvalid = 0; m_bresp = 2'd0; m_rresp = 2'd0; m_rdata = '0;
            m_pulse = '0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        end else begin
            aw_hs  = axil.awvalid && (aw_q.size() == 0);
            w_hs   = axil.wvalid && (wd_q.size() == 0);
            ar_hs  = axil.arvalid && (!m_rvalid || axil.rready);
            b_free = !m_bvalid || axil.bready;
            m_pulse = '0;
            if (ar_hs) begin
                ar_cnt++;
                a = axil.araddr / BB;
                m_rvalid = 1;
                if (a < RN) begin
                    m_rresp = 2'd0;
                    m_rdata = RO[a] ? ro_data[a] : m_regs[a];
                end else begin
                    m_rresp = 2'd2;
                    m_rdata = '0;
                end
            end else if (axil.rready) begin
                m_rvalid = 0;
            end
            if (m_bvalid && axil.bready) m_bvalid = 0;
            if (aw_q.size() > 0 && wd_q.size() > 0 && b_free) begin
                a = aw_q.pop_front() / BB;
                d = wd_q.pop_front();
                s = ws_q.pop_front();
                m_bvalid = 1;
                if (a >= RN || RO[a]) begin
                    m_bresp = 2'd2;
                end else begin
                    m_bresp = 2'd0;
                    if (s != '0) m_pulse[a] = 1'b1;
                    for (int b = 0; b < BB; b++)
                        if (s[b]) m_regs[a][8*b +: 8] = d[8*b +: 8];
                end
            end
            if (aw_hs) aw_q.push_back(axil.awaddr);
            if (w_hs) begin
                wd_q.push_back(axil.wdata);
                ws_q.push_back(axil.wstrb);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    logic [RN-1:0][DW-1:0] m_vec;
    always @(negedge clk) begin
        if (!arst) begin
            for (int k = 0; k < RN; k++) m_vec[k] = m_regs[k];
            check("awready", axil.awready, aw_q.size() == 0);
            check("wready", axil.wready, wd_q.size() == 0);
            check("arready", axil.arready, !m_rvalid || axil.rready);
            check("bvalid", axil.bvalid, m_bvalid);
            check("rvalid", axil.rvalid, m_rvalid);
            if (m_bvalid) check("bresp", axil.bresp, m_bresp);
            if (m_rvalid) begin
                check("rdata", axil.rdata, m_rdata);
                check("rresp", axil.rresp, m_rresp);
            end
            check("wr_pulse", wr_pulse, m_pulse);
            check("regs", regs, m_vec);
        end
    end

    int pulse1_cnt = 0, pulse_any_cnt = 0, r_cnt = 0, rv_run = 0, rv_max = 0;
    always @(negedge clk) begin
        if (!arst) begin
            if (wr_pulse[1]) pulse1_cnt++;
            if (|wr_pulse) pulse_any_cnt++;
            if (axil.rvalid && axil.rready) r_cnt++;
            rv_run = axil.rvalid ? rv_run + 1 : 0;
            if (rv_run > rv_max) rv_max = rv_run;
        end
    end

    task automatic wait_flag(input int which, input string nm);
        bit got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            got = (which == 0) ? aw_hs : (which == 1) ? w_hs : ar_hs;
        end
        check(nm, got, 1'b1);
    endtask

    task automatic drv_aw(input logic [AW-1:0] a, input int dly);
        if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
        axil.awaddr = a; axil.awvalid = 1'b1;
        wait_flag(0, "aw_hs_timeout");
        axil.awvalid = 1'b0;
    endtask

    task automatic drv_w(input logic [DW-1:0] d, input logic [BB-1:0] s, input int dly);
        if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
        axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1;
        wait_flag(1, "w_hs_timeout");
        axil.wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 0;
        resp = 2'b11;
        for (int i = 0; i < 50 && !got; i++) begin
            if (axil.bvalid) begin got = 1; resp = axil.bresp; end
            @(posedge clk); #1;
        end
        check("b_timeout", got, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BB-1:0] s, output logic [1:0] resp);
        fork
            drv_aw(a, 0);
            drv_w(d, s, 0);
        join
        wait_b(resp);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        axil.araddr = a; axil.arvalid = 1'b1;
        wait_flag(2, "ar_hs_timeout");
        axil.arvalid = 1'b0;
        check("read_latency", axil.rvalid, 1'b1);
        d = axil.rdata;
        r = axil.rresp;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0;
        return AW'($urandom_range(0, RN + 1) * BB + $urandom_range(0, BB - 1));
    endfunction

    logic [DW-1:0] rd;
    logic [1:0]    rr, br;
    int            a0, r0;
    bit            rnd_done;

    initial begin
        axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
        axil.awaddr = '0; axil.wdata = '0; axil.wstrb = '0; axil.araddr = '0;
        axil.bready = 1; axil.rready = 1;
        for (int k = 0; k < RN; k++) ro_data[k] = $urandom;
        ro_data[0] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk); #1;
        arst = 0;

        // Reset state
        check("rst_awready", axil.awready, 1'b1);
        check("rst_wready", axil.wready, 1'b1);
        check("rst_arready", axil.arready, 1'b1);
        check("rst_bvalid", axil.bvalid, 1'b0);
        check("rst_rvalid", axil.rvalid, 1'b0);
        check("rst_rdata", axil.rdata, 32'h0);
        check("rst_pulse", wr_pulse, 16'h0);
        check("rst_reg2", regs[2], 32'hA5A5_5A5A);

        // Basic write/read, then reset in the middle of a read
        do_write(32'h08, 32'h1234_5678, 4'hF, br);
        check("w2_bresp", br, 2'd0);
        do_read(32'h08, rd, rr);
        check("r2_data", rd, 32'h1234_5678);
        check("r2_resp", rr, 2'd0);
        @(posedge clk); #1;
        axil.rready = 0;
        axil.araddr = 32'h08; axil.arvalid = 1;
        wait_flag(2, "ar_hs_timeout");
        axil.arvalid = 0;
        check("midrd_rvalid", axil.rvalid, 1'b1);
        #3 arst = 1;
        #1;
        check("arst_rvalid", axil.rvalid, 1'b0);
        check("arst_rdata", axil.rdata, 32'h0);
        check("arst_awready", axil.awready, 1'b1);
        check("arst_bvalid", axil.bvalid, 1'b0);
        @(posedge clk); #1;
        arst = 0; axil.rready = 1;
        do_read(32'h08, rd, rr);
        check("r2_after_rst", rd, 32'hA5A5_5A5A);

        // Byte strobes
        do_write(32'h04, 32'hFFFF_FFFF, 4'hF, br);
        pulse1_cnt = 0;
        do_write(32'h04, 32'h00AB_00CD, 4'b0101, br);
        repeat (2) @(posedge clk); #1;
        check("strb_pulse_cnt", pulse1_cnt, 1);
        do_read(32'h04, rd, rr);
        check("strb_data", rd, 32'hFFAB_FFCD);

        // W leads AW by three cycles, then a stalled B
        @(posedge clk); #1;
        axil.bready = 0;
        fork
            drv_w(32'h0000_5555, 4'hF, 0);
            drv_aw(32'h14, 3);
        join
        check("order_bvalid_pre", axil.bvalid, 1'b0);
        @(posedge clk); #1;
        check("order_bvalid", axil.bvalid, 1'b1);
        check("order_bresp", axil.bresp, 2'd0);
        drv_aw(32'h18, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_bvalid", axil.bvalid, 1'b1);
            check("stall_bresp", axil.bresp, 2'd0);
            check("stall_awready", axil.awready, 1'b0);
        end
        drv_w(32'h0000_6666, 4'hF, 0);
        check("stall_wready", axil.wready, 1'b0);
        axil.bready = 1;
        @(posedge clk); #1;
        check("cont_bvalid", axil.bvalid, 1'b1);
        check("cont_reg6", regs[6], 32'h0000_6666);
        @(posedge clk); #1;
        check("cont_bvalid_drop", axil.bvalid, 1'b0);

        // Error responses and the read-only slot
        pulse_any_cnt = 0;
        do_write(32'h40, 32'h1111_1111, 4'hF, br);
        check("oor_bresp", br, 2'd2);
        do_write(32'h00, 32'h2222_2222, 4'hF, br);
        check("ro_bresp", br, 2'd2);
        repeat (2) @(posedge clk); #1;
        check("err_no_pulse", pulse_any_cnt, 0);
        do_read(32'h00, rd, rr);
        check("ro_rdata", rd, 32'hDEAD_BEEF);
        check("ro_rresp", rr, 2'd0);
        do_read(32'h40, rd, rr);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", rr, 2'd2);

        // Eight back-to-back reads
        @(posedge clk); #1;
        rv_max = 0;
        for (int i = 0; i < 8; i++) begin
            axil.araddr = AW'(i * BB); axil.arvalid = 1;
            @(posedge clk); #1;
            check("b2b_ar_hs", ar_hs, 1'b1);
        end
        axil.arvalid = 0;
        repeat (3) @(posedge clk); #1;
        check("b2b_run", rv_max, 8);

        // rready toggling: every accepted AR yields exactly one R beat
        a0 = ar_cnt; r0 = r_cnt;
        fork
            for (int i = 0; i < 6; i++) begin
                axil.araddr = AW'($urandom_range(1, RN - 1) * BB); axil.arvalid = 1;
                wait_flag(2, "ar_hs_timeout");
                axil.arvalid = 0;
            end
            for (int i = 0; i < 20; i++) begin
                axil.rready = ~axil.rready;
                @(posedge clk); #1;
            end
        join
        axil.rready = 1;
        repeat (3) @(posedge clk); #1;
        check("toggle_ar_cnt", ar_cnt - a0, 6);
        check("toggle_r_cnt", r_cnt - r0, 6);

        // Read and commit to reg 3 on the same edge
        do_write(32'h0C, 32'h3333_0000, 4'hF, br);
        fork
            drv_aw(32'h0C, 0);
            drv_w(32'h3333_1111, 4'hF, 0);
            begin
                @(posedge clk); #1;
                axil.araddr = 32'h0C; axil.arvalid = 1;
                wait_flag(2, "ar_hs_timeout");
                axil.arvalid = 0;
                rd = axil.rdata;
            end
        join
        check("coll_old", rd, 32'h3333_0000);
        repeat (3) @(posedge clk); #1;
        do_read(32'h0C, rd, rr);
        check("coll_new", rd, 32'h3333_1111);

        // Randomized traffic on all channels with random back-pressure
        @(posedge clk); #1;
        rnd_done = 0;
        fork
            begin
                fork
                    for (int i = 0; i < 150; i++) drv_aw(rand_addr(), $urandom_range(0, 3));
                    for (int i = 0; i < 150; i++) drv_w($urandom, BB'($urandom), $urandom_range(0, 3));
                    for (int i = 0; i < 200; i++) begin
                        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                        axil.araddr = rand_addr(); axil.arvalid = 1;
                        wait_flag(2, "ar_hs_timeout");
                        axil.arvalid = 0;
                    end
                join
                rnd_done = 1;
            end
            while (!rnd_done) begin
                axil.bready = ($urandom_range(0, 3) != 0);
                axil.rready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        join
        axil.bready = 1; axil.rready = 1;
        repeat (10) @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_axil_regs.md
# vga_axil_regs

Parametrised AXI4-Lite slave register bank: the RTL counterpart of the AXI4-Lite bus the VGA controller is configured over. Exposes REG_NUM software-visible registers, with byte-strobe writes, per-register read-only masking and SLVERR decode. AW and W are accepted independently, in any order. Sits between the AXI4-Lite interconnect and the VGA timing/pixel blocks, which consume the `regs_o` outputs and `wr_pulse_o` strobes.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8.
- `ADDR_W`, 32: address width.
- `REG_NUM`, 16: number of registers, ≥1.
- `RO_MASK`, '0: REG_NUM bits; bit k set = register k read-only, sourced from `ro_data_i`.
- `RESET_VAL`, '0: reset value of every RW register.
- `clk_i`  in  1  clock.
- `arst_i`  in  1  asynchronous, active-high reset.
- `awaddr_i`/`awvalid_i`  in  ADDR_W/1  AW channel; `awready_o`  out  1.
- `wdata_i`/`wstrb_i`/`wvalid_i`  in  DATA_W/DATA_W/8/1  W channel; `wready_o`  out  1.
- `bresp_o`  out  2, `bvalid_o`  out  1, `bready_i`  in  1  B channel.
- `araddr_i`/`arvalid_i`  in  ADDR_W/1  AR channel; `arready_o`  out  1.
- `rdata_o`  out  DATA_W, `rresp_o`  out  2, `rvalid_o`  out  1, `rready_i`  in  1  R channel.
- `regs_o`  out  REG_NUM×DATA_W  current RW register contents, packed array.
- `ro_data_i`  in  REG_NUM×DATA_W  hardware values returned for RO registers.
- `wr_pulse_o`  out  REG_NUM  one-cycle strobe, set when register k is successfully written.

## Operation
- Register index = addr[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits are ignored. Index ≥ REG_NUM → SLVERR (2), otherwise OKAY (0).
- AW and W each have a one-entry hold buffer. `awready_o` = AW buffer empty; `wready_o` = W buffer empty.
- Commit: on the first edge where both buffers are full and B is free (`!bvalid_o` or `bready_i`):
  - write each byte with its strobe bit set; pulse `wr_pulse_o[k]`; load `bresp_o`; set `bvalid_o`; empty both buffers.
  - Writes to an RO register or an out-of-range index return SLVERR, change nothing and produce no pulse.
  - `wstrb` all zero → OKAY, no change, no pulse.
- Read: AR handshake when `arready_o` = `!rvalid_o || rready_i`. The data is registered on that edge.
  - RW register → `regs_o[k]`; RO register → `ro_data_i[k]`; out of range → `rdata_o` = 0 with SLVERR.
- Read and write paths are independent.
  - Read and commit to the same register on the same edge: read returns the pre-write value.
- `bvalid_o`/`rvalid_o` stay high, with stable payload, until the matching ready is sampled high.

## Timing
- Reset (asynchronous, any time, including mid-transaction):
  - `bvalid_o`=`rvalid_o`=0, `bresp_o`=`rresp_o`=0, `rdata_o`=0, `wr_pulse_o`=0.
  - `awready_o`=`wready_o`=1, buffers empty, RW registers = RESET_VAL.
  - `arready_o`=1, via its definition.
  - In-flight transactions are dropped; no B/R is issued for them.
- AW and W handshake at edge N with B free: commit and `bvalid_o` at N+1; `wr_pulse_o` high for the cycle after N+1.
- AW at N, W at N+3: commit at N+4. AW is held; `awready_o` stays low N+1..N+4.
- Stalled B (`bready_i`=0): buffers stay full, `awready_o`/`wready_o` stay low.
  - Commit happens on the edge where `bready_i` is sampled high, so the next `bvalid_o` is continuous.
- Sustained write throughput: one per 2 cycles.
- Read latency: AR at N → `rvalid_o` at N+1.
- Back-to-back reads with `rready_i`=1: one read per cycle.

## Structure
- `vga_axil_pkg` gains:
  - `AXIL_RESP_OKAY`/`AXIL_RESP_SLVERR` values of `axil_resp_e`.
  - a `axil_reg_idx` function for address-to-index decode.
- Strobe width derives from DATA_W as in the existing interface.
- Sub-module `vga_axil_hold_buf` (parametrised payload type, one-entry valid/ready buffer) is instantiated twice, for AW {addr} and W {data, strb}.
- Ports map 1:1 onto the `slave` modport of `vga_axil_if`.

## Test plan
- Reset: write 0x1234_5678 to reg 2; read reg 2 → 0x1234_5678 OKAY. Assert `arst_i` mid-read → `rvalid_o`=0; read reg 2 → RESET_VAL.
- Byte strobes: reg 1 = 0xFFFF_FFFF; write 0x00AB_00CD with strb 4'b0101 → reads 0xFFAB_FFCD; `wr_pulse_o[1]` high exactly 1 cycle.
- Ordering: W at N, AW at N+3 → `bvalid_o` at N+4, OKAY. Hold `bready_i`=0 for 5 cycles → `bvalid_o`/`bresp_o` stable, `awready_o`=0.
- Errors: write to index REG_NUM → SLVERR, no pulse. With RO_MASK bit 0 set, write reg 0 → SLVERR, and read reg 0 with `ro_data_i[0]`=0xDEAD_BEEF → 0xDEAD_BEEF OKAY.
- Reads: 8 back-to-back reads, `rready_i`=1 → 8 consecutive `rvalid_o` cycles. Toggle `rready_i` 1/0 → no lost or duplicated beats.
- Collision: read and commit to reg 3 on the same edge → old value returned; the next read returns the new value.
